// File: rtl/infer_sched_if.sv
// Bundle of request, engine, result and status signals for the inference scheduler.
// slave is the scheduler side; master is the requester/engine side.
interface infer_sched_if #(
  parameter int DATA_WIDTH = 13,
  parameter int ADDR_WIDTH = 16,
  parameter int TAG_WIDTH  = 8
);
  logic                         req_valid;
  logic                         req_ready;
  logic        [ADDR_WIDTH-1:0] req_base;
  logic        [TAG_WIDTH-1:0]  req_tag;

  logic                         eng_start;
  logic                         eng_reset;
  logic                         eng_done;
  logic        [ADDR_WIDTH-1:0] eng_addr;
  logic        [ADDR_WIDTH-1:0] mem_addr;
  logic        [3:0]            eng_out_idx;
  logic signed [DATA_WIDTH-1:0] eng_out;

  logic                         res_valid;
  logic                         res_ready;
  logic        [3:0]            res_class;
  logic signed [DATA_WIDTH-1:0] res_score;
  logic        [TAG_WIDTH-1:0]  res_tag;
  logic                         res_err;

  logic                         busy;
  logic        [15:0]           done_cnt;

  modport slave (
    input  req_valid, req_base, req_tag,
    input  eng_done, eng_addr, eng_out,
    input  res_ready,
    output req_ready,
    output eng_start, eng_reset, mem_addr, eng_out_idx,
    output res_valid, res_class, res_score, res_tag, res_err,
    output busy, done_cnt
  );

  modport master (
    output req_valid, req_base, req_tag,
    output eng_done, eng_addr, eng_out,
    output res_ready,
    input  req_ready,
    input  eng_start, eng_reset, mem_addr, eng_out_idx,
    input  res_valid, res_class, res_score, res_tag, res_err,
    input  busy, done_cnt
  );
endinterface

// File: rtl/infer_sched.sv
// Inference scheduler: runs one engine job per request, scans 10 scores for the argmax, returns it.
// Optional engine watchdog enabled by defining INFER_TIMEOUT_EN.
module infer_sched #(
  parameter int DATA_WIDTH  = 13,
  parameter int ADDR_WIDTH  = 16,
  parameter int TAG_WIDTH   = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic         clk,
  input logic         rst,
  infer_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_START,
    S_WAIT,
    S_SCAN,
    S_RESP
  } state_t;

  state_t                       r_state;
  state_t                       w_nextState;
  logic        [ADDR_WIDTH-1:0] r_base;
  logic        [TAG_WIDTH-1:0]  r_tag;
  logic        [3:0]            r_idx;
  logic        [3:0]            r_bestIdx;
  logic signed [DATA_WIDTH-1:0] r_bestScore;
  logic                         r_err;
  logic        [15:0]           r_doneCnt;
  logic                         w_timeout;
  logic                         w_inResp;

`ifdef INFER_TIMEOUT_EN
  logic [15:0] r_wdog;

  // Watchdog restarts every time WAIT is entered (START always precedes WAIT).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (r_state == S_START) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !bus.eng_done &&
                     (r_wdog == 16'(TIMEOUT_CYC - 1));
`else
  if (TIMEOUT_CYC < 1) begin : g_badTimeoutCfg
  end

  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_nextState = S_CLR;
      S_CLR:   w_nextState = S_START;
      S_START: w_nextState = S_WAIT;
      S_WAIT: begin
        if (bus.eng_done) begin
          w_nextState = S_SCAN;
        end else if (w_timeout) begin
          w_nextState = S_RESP;
        end
      end
      S_SCAN:  if (r_idx == 4'd9) w_nextState = S_RESP;
      S_RESP:  if (bus.res_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, argmax during SCAN, count completions on result handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_tag       <= '0;
      r_idx       <= '0;
      r_bestIdx   <= '0;
      r_bestScore <= '0;
      r_err       <= 1'b0;
      r_doneCnt   <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_base <= bus.req_base;
            r_tag  <= bus.req_tag;
            r_err  <= 1'b0;
          end
        end
        S_WAIT: begin
          r_idx <= '0;
          if (!bus.eng_done && w_timeout) begin
            r_err       <= 1'b1;
            r_bestIdx   <= '0;
            r_bestScore <= '0;
          end
        end
        S_SCAN: begin
          r_idx <= r_idx + 4'd1;
          // Strictly-greater keeps the lowest index on ties.
          if ((r_idx == 4'd0) || ($signed(bus.eng_out) > r_bestScore)) begin
            r_bestIdx   <= r_idx;
            r_bestScore <= bus.eng_out;
          end
        end
        S_RESP: begin
          if (bus.res_ready) r_doneCnt <= r_doneCnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_inResp = (r_state == S_RESP);

  assign bus.req_ready   = rst && (r_state == S_IDLE);
  assign bus.eng_reset   = rst && ((r_state == S_CLR) || w_timeout);
  assign bus.eng_start   = rst && (r_state == S_START);
  assign bus.mem_addr    = bus.eng_addr + r_base;
  assign bus.eng_out_idx = (r_state == S_SCAN) ? r_idx : 4'd0;
  assign bus.res_valid   = w_inResp;
  assign bus.res_class   = w_inResp ? r_bestIdx : 4'd0;
  assign bus.res_score   = w_inResp ? r_bestScore : '0;
  assign bus.res_tag     = w_inResp ? r_tag : '0;
  assign bus.res_err     = w_inResp && r_err;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done_cnt    = r_doneCnt;

endmodule

// File: doc/infer_sched.md
INFER_SCHED -- requirements
Module: infer_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 13, engine score width (signed fixed-point).
REQ-002 Parameter ADDR_WIDTH, default 16, memory address width.
REQ-003 Parameter TAG_WIDTH, default 8, request tag width.
REQ-004 Parameter TIMEOUT_CYC, default 65535, watchdog limit in cycles (used only under INFER_TIMEOUT_EN).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 req_valid  in  1 / req_ready  out  1  inference request handshake.
REQ-008 req_base  in  ADDR_WIDTH  image/weight base address; req_tag  in  TAG_WIDTH  request tag.
REQ-009 eng_start  out  1 / eng_reset  out  1  engine controls; eng_done  in  1  engine completion.
REQ-010 eng_addr  in  ADDR_WIDTH  engine-relative address; mem_addr  out  ADDR_WIDTH  translated memory address.
REQ-011 eng_out_idx  out  4  score select; eng_out  in  DATA_WIDTH signed  selected score (combinational from eng_out_idx).
REQ-012 res_valid  out  1 / res_ready  in  1  result handshake.
REQ-013 res_class  out  4, res_score  out  DATA_WIDTH signed, res_tag  out  TAG_WIDTH, res_err  out  1.
REQ-014 busy  out  1  high in every state except IDLE; done_cnt  out  16  completed-request counter.

Function
REQ-015 FSM states: IDLE, CLR, START, WAIT, SCAN, RESP.
REQ-016 IDLE: req_ready=1; on req_valid, capture req_base/req_tag and go to CLR.
REQ-017 CLR: eng_reset=1 for exactly one cycle, then START.
REQ-018 START: eng_start=1 for exactly one cycle, then WAIT.
REQ-019 WAIT: hold until eng_done=1, then SCAN with index counter 0; eng_done outside WAIT is ignored.
REQ-020 mem_addr = eng_addr + captured base, modulo 2^ADDR_WIDTH (wrap, no carry out), combinational in all states.
REQ-021 SCAN: eng_out_idx = counter, counter 0..9, one index per cycle, exactly 10 cycles.
REQ-022 Argmax: signed compare; index 0 loads unconditionally; later index replaces only if strictly greater (ties keep lowest index).
REQ-023 After index 9, go to RESP with res_class/res_score = argmax result, res_tag = captured tag, res_err=0.
REQ-024 RESP: res_valid=1, outputs stable until res_ready=1; on handshake go to IDLE, done_cnt increments (wraps 0xFFFF->0).
REQ-025 req_ready=0 in all non-IDLE states; back-to-back request accepted earliest the cycle after RESP handshake.
REQ-026 Latency from eng_done sampled high to res_valid high: 11 cycles; from request accept to eng_start: 2 cycles.
REQ-027 eng_out_idx = 0 outside SCAN.

Reset
REQ-028 rst=0 at a clock edge: state IDLE, all outputs 0 except req_ready=1 after release; captured regs, argmax regs, done_cnt cleared.
REQ-029 Reset mid-operation abandons the request with no result; engine not pulsed (eng_reset=0) during reset.

Configuration
REQ-030 Macro INFER_TIMEOUT_EN defined: 16-bit watchdog clears on entering WAIT, increments each WAIT cycle; reaching TIMEOUT_CYC without eng_done -> pulse eng_reset one cycle, go to RESP with res_err=1, res_class=0, res_score=0.
REQ-031 Macro INFER_TIMEOUT_EN undefined: no watchdog logic, WAIT unbounded, res_err tied 0.
REQ-032 done_cnt counts errored results too.

Verification
REQ-033 Request base=0x1000 tag=0x5A; engine done after 50 cycles with scores {3,-2,7,1,7,0,-5,2,6,4} -> class 2, score 7, tag 0x5A, res_err 0.
REQ-034 eng_addr=0xF800 with base 0x1000 -> mem_addr=0x0800.
REQ-035 All scores -4096 -> class 0, score -4096; res_ready held 0 for 5 cycles -> res_valid and outputs stable, req_ready 0.
REQ-036 rst=0 asserted in WAIT -> next cycle IDLE, busy 0, no res_valid; new request processed normally.
REQ-037 INFER_TIMEOUT_EN, TIMEOUT_CYC=20, eng_done never asserted -> eng_reset pulse, res_valid with res_err=1, class 0.
REQ-038 Counter wrap: 65536 completed requests from preload path (force done_cnt=0xFFFF) -> done_cnt=0 after next handshake.
